aes128_encrypt_iter: RTL



---
 rtl/aes128_encrypt_iter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/aes128_encrypt_iter.sv
// ============================================================================
// Module   : aes128_encrypt_iter
// Brief    : Iterative AES-128 encryptor, one round per clock, on-the-fly key
//            expansion. Optional macro AES_ENC_ZEROIZE_EN clears cipher_o on accept.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes128_encrypt_iter (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] text_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [127:0] cipher_o
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ROUND = 1'b1;

    localparam logic [7:0] C_SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return C_SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [0:0]   fsm_q,    fsm_d;
    logic [127:0] state_q,  state_d;
    logic [127:0] rkey_q,   rkey_d;
    logic [7:0]   rcon_q,   rcon_d;
    logic [3:0]   round_q,  round_d;
    logic [127:0] cipher_q, cipher_d;
    logic         done_q,   done_d;

    logic         w_accept;
    logic         w_last;
    logic [127:0] w_sub_shift;
    logic [127:0] w_mix;
    logic [31:0]  w_sub_word;
    logic [127:0] w_key_next;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            fsm_q    <= S_IDLE;
            state_q  <= 128'h0;
            rkey_q   <= 128'h0;
            rcon_q   <= 8'h00;
            round_q  <= 4'd0;
            cipher_q <= 128'h0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            rkey_q   <= rkey_d;
            rcon_q   <= rcon_d;
            round_q  <= round_d;
            cipher_q <= cipher_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (start_i)          fsm_d = S_ROUND;
            S_ROUND: if (round_q == 4'd10) fsm_d = S_IDLE;
            default:                       fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o  = (fsm_q == S_IDLE);
        done_o   = done_q;
        cipher_o = cipher_q;
    end

    // Byte b of the 128-bit word sits at [127-8b -: 8]; b = 4*column + row.
    always_comb begin
        w_sub_shift = 128'h0;
        w_mix       = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sub_shift[127-8*(4*c+r) -: 8] = sbox(state_q[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mix[127-32*c -: 32] = mix_col(w_sub_shift[127-32*c -: 32]);
        end
        w_sub_word = {sbox(rkey_q[23:16]), sbox(rkey_q[15:8]),
                      sbox(rkey_q[7:0]),   sbox(rkey_q[31:24])} ^ {rcon_q, 24'h0};
        w_key_next[127:96] = rkey_q[127:96] ^ w_sub_word;
        w_key_next[95:64]  = rkey_q[95:64]  ^ w_key_next[127:96];
        w_key_next[63:32]  = rkey_q[63:32]  ^ w_key_next[95:64];
        w_key_next[31:0]   = rkey_q[31:0]   ^ w_key_next[63:32];
    end

    assign w_accept = (fsm_q == S_IDLE) && start_i;
    assign w_last   = (fsm_q == S_ROUND) && (round_q == 4'd10);

    always_comb begin
        state_d  = state_q;
        rkey_d   = rkey_q;
        rcon_d   = rcon_q;
        round_d  = round_q;
        cipher_d = cipher_q;
        done_d   = 1'b0;
        if (w_accept) begin
            state_d = text_i ^ key_i;
            rkey_d  = key_i;
            rcon_d  = 8'h01;
            round_d = 4'd1;
`ifdef AES_ENC_ZEROIZE_EN
            cipher_d = 128'h0;
`else
            cipher_d = cipher_q;
`endif
        end else if (fsm_q == S_ROUND) begin
            state_d = (w_last ? w_sub_shift : w_mix) ^ w_key_next;
            rkey_d  = w_key_next;
            rcon_d  = xtime(rcon_q);
            round_d = round_q + 4'd1;
            if (w_last) begin
                cipher_d = w_sub_shift ^ w_key_next;
                done_d   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
